// File: rtl/fptd_ctrl_pkg.sv
// Shared types for the FPTD section-array control path.
// No logic; states, half-iteration phase and the replay counter width.
// Consumers import fptd_ctrl_pkg::*.
package fptd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_RECOVER,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_ODD  = 1'b0,
    PH_EVEN = 1'b1
  } phase_t;

  localparam int REPLAY_W = 8;

  function automatic logic [REPLAY_W-1:0] sat_inc(input logic [REPLAY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/razor_err_collector.sv
// OR-collects Alpha/Beta/be1 Razor error flags of every section into one flag.
// Latency: purely combinational.
// Backpressure: none; the flag is consumed by the caller in the same cycle.
module razor_err_collector #(
  parameter int NUM_SECTIONS = 8
) (
  input  logic [2*NUM_SECTIONS-1:0] err_alpha,
  input  logic [2*NUM_SECTIONS-1:0] err_beta,
  input  logic [2*NUM_SECTIONS-1:0] err_be1,
  output logic                      err_any
);

  assign err_any = |{err_alpha, err_beta, err_be1};

endmodule

// File: rtl/fptd_razor_scheduler.sv
// Odd/even half-iteration sequencer that squashes, stalls and replays Razor-flagged halves.
// Latency: Start@0, Load@1, halves @2..2N+1, Done@2N+3 without errors.
// Backpressure: Start ignored while Busy; each detected error costs a squash plus STALL_CYCLES.
module fptd_razor_scheduler
  import fptd_ctrl_pkg::*;
#(
  parameter int NUM_SECTIONS = 8,
  parameter int ITER_W       = 6,
  parameter int STALL_CYCLES = 1,
  parameter int MAX_REPLAY   = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [ITER_W-1:0]         NumIter,
  input  logic [2*NUM_SECTIONS-1:0] Err_alpha,
  input  logic [2*NUM_SECTIONS-1:0] Err_beta,
  input  logic [2*NUM_SECTIONS-1:0] Err_be1,
  output logic                      Load,
  output logic                      Enable_odd,
  output logic                      Enable_even,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Fail,
  output logic [ITER_W-1:0]         IterCount,
  output logic [REPLAY_W-1:0]       ReplayCount
);

  localparam int HW = ITER_W + 1;
  localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam int CW = $clog2(MAX_REPLAY + 1);

  state_t              state_q, state_nxt;
  phase_t              phase_nxt;
  logic [HW-1:0]       half_q, half_nxt;
  logic [ITER_W-1:0]   num_iter_q;
  logic [ITER_W-1:0]   iter_q, iter_nxt;
  logic [REPLAY_W-1:0] replay_q, replay_nxt;
  logic [CW-1:0]       consec_q, consec_nxt;
  logic [SW-1:0]       stall_q, stall_nxt;
  logic                fail_q, fail_nxt;
  logic                issued_q;
  logic                load_q, busy_q, done_q, en_odd_q, en_even_q;
  logic                err_any, squash, err_hit, last_half;

  razor_err_collector #(
    .NUM_SECTIONS(NUM_SECTIONS)
  ) u_err (
    .err_alpha (Err_alpha),
    .err_beta  (Err_beta),
    .err_be1   (Err_be1),
    .err_any   (err_any)
  );

  // A flag only matters when a half actually went out on the previous cycle.
  assign squash    = (state_q == ST_RUN) && issued_q && err_any;
  assign last_half = (half_q == ({num_iter_q, 1'b0} - HW'(1)));

  always_comb begin
    state_nxt  = state_q;
    half_nxt   = half_q;
    iter_nxt   = iter_q;
    replay_nxt = replay_q;
    consec_nxt = consec_q;
    stall_nxt  = stall_q;
    fail_nxt   = fail_q;
    err_hit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_nxt  = ST_LOAD;
          half_nxt   = '0;
          iter_nxt   = '0;
          replay_nxt = '0;
          consec_nxt = '0;
          fail_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        half_nxt  = '0;
        state_nxt = (num_iter_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (squash) begin
          err_hit  = 1'b1;
          half_nxt = half_q - HW'(1);
        end else begin
          if (issued_q) begin
            consec_nxt = '0;
            // Even index in flight means the committed half had odd index: an even half.
            if (!half_q[0]) iter_nxt = iter_q + ITER_W'(1);
          end
          if (last_half) state_nxt = ST_DRAIN;
          else           half_nxt  = half_q + HW'(1);
        end
      end
      ST_DRAIN: begin
        if (err_any) begin
          err_hit = 1'b1;
        end else begin
          consec_nxt = '0;
          iter_nxt   = iter_q + ITER_W'(1);
          state_nxt  = ST_DONE;
        end
      end
      ST_RECOVER: begin
        if (stall_q == SW'(STALL_CYCLES - 1)) state_nxt = ST_RUN;
        else                                  stall_nxt = stall_q + SW'(1);
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (err_hit) begin
      replay_nxt = sat_inc(replay_q);
      consec_nxt = consec_q + CW'(1);
      stall_nxt  = '0;
      if (consec_nxt == CW'(MAX_REPLAY)) begin
        state_nxt = ST_DONE;
        fail_nxt  = 1'b1;
      end else begin
        state_nxt = ST_RECOVER;
      end
    end
  end

  assign phase_nxt = phase_t'(half_nxt[0]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      num_iter_q <= '0;
      iter_q     <= '0;
      replay_q   <= '0;
      consec_q   <= '0;
      stall_q    <= '0;
      fail_q     <= 1'b0;
      issued_q   <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_odd_q   <= 1'b0;
      en_even_q  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      half_q     <= half_nxt;
      iter_q     <= iter_nxt;
      replay_q   <= replay_nxt;
      consec_q   <= consec_nxt;
      stall_q    <= stall_nxt;
      fail_q     <= fail_nxt;
      if (state_q == ST_IDLE && Start) num_iter_q <= NumIter;
      issued_q   <= (state_q == ST_RUN) && !squash;
      load_q     <= (state_nxt == ST_LOAD);
      busy_q     <= (state_nxt != ST_IDLE);
      done_q     <= (state_nxt == ST_DONE);
      en_odd_q   <= (state_nxt == ST_RUN) && (phase_nxt == PH_ODD);
      en_even_q  <= (state_nxt == ST_RUN) && (phase_nxt == PH_EVEN);
    end
  end

  assign Load        = load_q;
  assign Enable_odd  = en_odd_q & ~squash;
  assign Enable_even = en_even_q & ~squash;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Fail        = fail_q;
  assign IterCount   = iter_q;
  assign ReplayCount = replay_q;

endmodule
